// File: rtl/soc_sram_sp_pkg.sv
// Shared types for the single-port SRAM initiator: FSM states, response FIFO entry, word sizing.
package soc_sram_sp_pkg;

  typedef enum logic {StClear, StRun} state_e;

  // Widest supported data word; narrower configurations use the low bits.
  localparam int unsigned RspDataW = 32;

  typedef struct packed {
    logic                err;
    logic [RspDataW-1:0] rdata;
  } rsp_entry_t;

  function automatic int unsigned sw_from_xlen(input int unsigned xlen);
    return xlen / 8;
  endfunction

endpackage

// File: rtl/soc_sram_rsp_fifo.sv
// Synchronous response FIFO with occupancy count; synchronous active-high flush.
module soc_sram_rsp_fifo #(
  parameter  int unsigned Depth = 3,
  parameter  int unsigned Width = 33,
  localparam int unsigned CntW  = $clog2(Depth + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [Width-1:0] wdata,
  input  logic             pop,
  output logic [Width-1:0] rdata,
  output logic [CntW-1:0]  count,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count_q == CntW'(Depth));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
    if (do_push && !do_pop) begin
      count_d = count_q + 1'b1;
    end else if (do_pop && !do_push) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !rst) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

endmodule

// File: rtl/soc_sram_sp_ctrl.sv
// Valid/ready word initiator for a single-port SRAM with ordered read responses.
// Optional post-reset zero-fill of the array when SRAM_CLEAR_EN is defined.
module soc_sram_sp_ctrl
  import soc_sram_sp_pkg::*;
#(
  parameter  int unsigned PLEN          = 32,
  parameter  int unsigned XLEN          = 32,
  parameter  int unsigned MEM_SIZE_BYTE = 1024,
  parameter  int unsigned RSP_DEPTH     = 3,
  localparam int unsigned SW            = sw_from_xlen(XLEN),
  localparam int unsigned WORD_AW       = PLEN - (SW >> 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_we,
  input  logic [WORD_AW-1:0] req_addr,
  input  logic [XLEN-1:0]    req_wdata,
  input  logic [SW-1:0]      req_sel,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [XLEN-1:0]    rsp_rdata,
  output logic               rsp_err,
  output logic               wr_err,
  output logic               busy,
  output logic               sram_ce,
  output logic               sram_we,
  output logic               sram_oe,
  output logic [WORD_AW-1:0] sram_waddr,
  output logic [XLEN-1:0]    sram_din,
  output logic [SW-1:0]      sram_sel,
  input  logic [XLEN-1:0]    sram_dout
);

  localparam int unsigned MEM_SIZE_WORDS = MEM_SIZE_BYTE / SW;
  localparam int unsigned CntW           = $clog2(RSP_DEPTH + 1);
  localparam int unsigned EntryW         = $bits(rsp_entry_t);

  state_e          state_q, state_d;
  logic            inflight_q, inflight_d;
  logic            inflight_err_q, inflight_err_d;
  logic            wr_err_q, wr_err_d;
  logic            in_range;
  logic            accept;
  logic [CntW-1:0] fifo_count;
  logic            fifo_full, fifo_empty;
  logic            fifo_pop;
  rsp_entry_t      push_entry, head_entry;
  logic [EntryW-1:0] fifo_rdata;

`ifdef SRAM_CLEAR_EN
  localparam int unsigned ClrW = (MEM_SIZE_WORDS > 1) ? $clog2(MEM_SIZE_WORDS) : 1;
  logic [ClrW-1:0] clr_q, clr_d;
`endif

  assign in_range = (req_addr < WORD_AW'(MEM_SIZE_WORDS));

  // Reserve a FIFO slot for every read still in the SRAM pipeline.
  assign req_ready = !rst && (state_q == StRun) && !fifo_full &&
                     ((32'(fifo_count) + 32'(inflight_q)) < RSP_DEPTH);
  assign accept    = req_valid && req_ready;

  always_comb begin
    sram_ce    = accept && in_range;
    sram_we    = accept && in_range && req_we;
    sram_oe    = accept && in_range && !req_we;
    sram_waddr = req_addr;
    sram_din   = req_wdata;
    sram_sel   = req_sel;
`ifdef SRAM_CLEAR_EN
    if (state_q == StClear && !rst) begin
      sram_ce    = 1'b1;
      sram_we    = 1'b1;
      sram_oe    = 1'b0;
      sram_waddr = WORD_AW'(clr_q);
      sram_din   = '0;
      sram_sel   = '1;
    end
`endif
  end

  always_comb begin
    state_d        = state_q;
    inflight_d     = accept && !req_we;
    inflight_err_d = !in_range;
    wr_err_d       = accept && req_we && !in_range;
`ifdef SRAM_CLEAR_EN
    clr_d = clr_q;
    if (state_q == StClear) begin
      clr_d = clr_q + 1'b1;
      if (clr_q == ClrW'(MEM_SIZE_WORDS - 1)) begin
        state_d = StRun;
        clr_d   = '0;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
`ifdef SRAM_CLEAR_EN
      state_q <= StClear;
      clr_q   <= '0;
`else
      state_q <= StRun;
`endif
      inflight_q     <= 1'b0;
      inflight_err_q <= 1'b0;
      wr_err_q       <= 1'b0;
    end else begin
`ifdef SRAM_CLEAR_EN
      clr_q <= clr_d;
`endif
      state_q        <= state_d;
      inflight_q     <= inflight_d;
      inflight_err_q <= inflight_err_d;
      wr_err_q       <= wr_err_d;
    end
  end

  always_comb begin
    push_entry.err   = inflight_err_q;
    push_entry.rdata = inflight_err_q ? '0 : RspDataW'(sram_dout);
  end

  assign fifo_pop   = rsp_valid && rsp_ready;
  assign head_entry = rsp_entry_t'(fifo_rdata);

  soc_sram_rsp_fifo #(
    .Depth (RSP_DEPTH),
    .Width (EntryW)
  ) u_rsp_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (inflight_q),
    .wdata (EntryW'(push_entry)),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign rsp_valid = !fifo_empty;
  assign rsp_rdata = rsp_valid ? head_entry.rdata[XLEN-1:0] : '0;
  assign rsp_err   = rsp_valid && head_entry.err;
  assign wr_err    = wr_err_q;

`ifdef SRAM_CLEAR_EN
  assign busy = (state_q == StClear);
`else
  assign busy = 1'b0;
`endif

endmodule
